// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for a multicycle RV32 subset datapath
// State-only decode for datapath selects; PCWrite and ImmSrc also look at the instruction fields.
module multicycle_controller #(
  parameter int BNE_EN = 1,
  parameter int JAL_EN = 1,
  parameter int IMM_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       supported;
  logic       pc_update;
  logic       branch;
  logic       taken;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Optional opcodes fall back to the illegal path when their feature is disabled.
  always_comb begin
    supported = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_BR: supported = 1'b1;
      OP_I:                      supported = (IMM_EN != 0);
      OP_JAL:                    supported = (JAL_EN != 0);
      default:                   supported = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = S_FETCH;
        if (supported) begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECUTER;
            OP_I:         state_d = S_EXECUTEI;
            OP_JAL:       state_d = S_JAL;
            OP_BR:        state_d = S_BEQ;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = ~supported;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (funct3 == 3'b000)                      taken = zero;
    else if (funct3 == 3'b001 && BNE_EN != 0)  taken = ~zero;
  end

  assign PCWrite = pc_update | (branch & taken);

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized check of multicycle_controller against an instruction-level model
// Instance 0 uses default parameters, instance 1 has every optional feature disabled.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_s  [2];
  logic [2:0] f3_s  [2];
  logic       zero_s[2];
  logic       mr_s  [2];
  logic       pcw [2], adr [2], mw [2], irw [2], rw [2], ill [2], done [2];
  logic [1:0] rs [2], sa [2], sb [2], aop [2], imm [2];
  logic [3:0] st [2];
  int         bne_en [2] = '{1, 0};
  int         jal_en [2] = '{1, 0};
  int         imm_en [2] = '{1, 0};
  int         n_checks = 0;
  int         n_err = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0110111;

  always #5 clk = ~clk;

  multicycle_controller dut0 (
    .clk(clk), .reset(reset), .op(op_s[0]), .funct3(f3_s[0]), .zero(zero_s[0]),
    .mem_ready(mr_s[0]), .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(mw[0]),
    .IRWrite(irw[0]), .RegWrite(rw[0]), .ResultSrc(rs[0]), .ALUSrcA(sa[0]),
    .ALUSrcB(sb[0]), .ALUOp(aop[0]), .ImmSrc(imm[0]), .illegal(ill[0]),
    .instr_done(done[0]), .state(st[0])
  );

  multicycle_controller #(.BNE_EN(0), .JAL_EN(0), .IMM_EN(0)) dut1 (
    .clk(clk), .reset(reset), .op(op_s[1]), .funct3(f3_s[1]), .zero(zero_s[1]),
    .mem_ready(mr_s[1]), .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(mw[1]),
    .IRWrite(irw[1]), .RegWrite(rw[1]), .ResultSrc(rs[1]), .ALUSrcA(sa[1]),
    .ALUSrcB(sb[1]), .ALUOp(aop[1]), .ImmSrc(imm[1]), .illegal(ill[1]),
    .instr_done(done[1]), .state(st[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected control word {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,illegal,instr_done}.
  function automatic logic [16:0] exp_vec(int k, int s, logic [6:0] o, logic [2:0] f3,
                                          logic z, logic mr, logic last, logic illp);
    logic       p, a, m, i, r, il, d;
    logic [1:0] res, srca, srcb, alu, im;
    p = 0; a = 0; m = 0; i = 0; r = 0; il = 0; d = 0;
    res = 0; srca = 0; srcb = 0; alu = 0;
    im = (o == SW) ? 2'd1 : (o == BR) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
    case (s)
      0:  begin srcb = 2; res = 2; i = mr; p = mr; end
      1:  begin srca = 1; srcb = 1; il = illp; end
      2:  begin srca = 2; srcb = 1; end
      7:  begin srca = 2; srcb = 1; alu = 2; end
      3:  a = 1;
      5:  begin a = 1; m = 1; end
      4:  begin res = 1; r = 1; end
      8:  r = 1;
      6:  begin srca = 2; alu = 2; end
      9:  begin srca = 1; srcb = 2; p = 1; end
      10: begin
        srca = 2; alu = 1;
        p = (f3 == 3'd0 && z) || (bne_en[k] != 0 && f3 == 3'd1 && !z);
      end
      default: ;
    endcase
    d = last && !illp && (s != 5 || mr);
    return {p, a, m, i, r, res, srca, srcb, alu, im, il, d};
  endfunction

  task automatic step(input int k, input int s, input logic mr, input logic last, input logic illp);
    @(negedge clk);
    mr_s[k] = mr;
    #1;
    check_eq("state", 32'(st[k]), 32'(s));
    check_eq("outs", 32'({pcw[k], adr[k], mw[k], irw[k], rw[k], rs[k], sa[k], sb[k], aop[k],
                          imm[k], ill[k], done[k]}),
             32'(exp_vec(k, s, op_s[k], f3_s[k], zero_s[k], mr, last, illp)));
  endtask

  // One instruction from FETCH until back in FETCH; stall<0 picks random memory wait states.
  task automatic run_instr(input int k, input logic [6:0] o, input logic [2:0] f3,
                           input logic z, input int stall);
    int   plan[$];
    logic illp;
    logic mr;
    int   waits;
    bit   stall_state;
    illp = 0;
    plan = {0, 1};
    case (o)
      LW: plan = {plan, 2, 3, 4};
      SW: plan = {plan, 2, 5};
      RT: plan = {plan, 6, 8};
      IT: if (imm_en[k] != 0) plan = {plan, 7, 8}; else illp = 1;
      JL: if (jal_en[k] != 0) plan = {plan, 9, 8}; else illp = 1;
      BR: plan = {plan, 10};
      default: illp = 1;
    endcase
    op_s[k] = o; f3_s[k] = f3; zero_s[k] = z;
    for (int idx = 0; idx < plan.size(); idx++) begin
      stall_state = (plan[idx] == 0 || plan[idx] == 3 || plan[idx] == 5);
      waits = 0;
      do begin
        if (!stall_state) mr = 1'($urandom_range(0, 1));
        else if (stall >= 0) mr = (waits >= stall);
        else mr = ($urandom_range(0, 3) != 0) || (waits >= 8);
        step(k, plan[idx], mr, idx == plan.size() - 1, illp);
        waits++;
      end while (stall_state && !mr);
    end
    @(negedge clk);
    mr_s[k] = 0;
  endtask

  function automatic logic [6:0] rand_op();
    int sel;
    logic [6:0] o;
    sel = $urandom_range(0, 6);
    case (sel)
      0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = JL; 5: o = BR;
      default: begin
        o = 7'($urandom);
        if (o == LW || o == SW || o == RT || o == IT || o == JL || o == BR) o = BAD;
      end
    endcase
    return o;
  endfunction

  initial begin
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      op_s[k] = BAD; f3_s[k] = 0; zero_s[k] = 0; mr_s[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 0;
    for (int k = 0; k < 2; k++) step(k, 0, 1'b0, 1'b0, 1'b0);

    run_instr(0, LW, 3'd2, 0, 0);
    run_instr(0, SW, 3'd2, 0, 3);
    run_instr(0, JL, 3'd0, 0, 0);
    run_instr(0, RT, 3'd0, 1, 0);
    run_instr(0, IT, 3'd0, 0, 0);
    run_instr(0, BR, 3'd0, 1, 0);
    run_instr(0, BR, 3'd1, 0, 0);
    run_instr(0, BR, 3'd1, 1, 0);
    run_instr(0, BAD, 3'd0, 0, 0);
    run_instr(1, JL, 3'd0, 0, 0);
    run_instr(1, IT, 3'd0, 0, 0);
    run_instr(1, BR, 3'd1, 0, 0);
    run_instr(1, BR, 3'd0, 1, 0);
    run_instr(1, RT, 3'd0, 0, 1);

    for (int n = 0; n < 150; n++)
      run_instr(0, rand_op(), 3'($urandom), 1'($urandom), -1);
    for (int n = 0; n < 60; n++)
      run_instr(1, rand_op(), 3'($urandom), 1'($urandom), -1);

    // Reset arriving in the middle of a load's memory stall.
    op_s[0] = LW; f3_s[0] = 3'd2; zero_s[0] = 0;
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step(0, 1, 1'b1, 1'b0, 1'b0);
    step(0, 2, 1'b1, 1'b0, 1'b0);
    step(0, 3, 1'b0, 1'b0, 1'b0);
    step(0, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1;
    mr_s[0] = 0;
    #1;
    check_eq("rst_hold_state", 32'(st[0]), 32'd3);
    check_eq("rst_hold_regwrite", 32'(rw[0]), 32'd0);
    @(negedge clk);
    reset = 0;
    #1;
    check_eq("rst_state", 32'(st[0]), 32'd0);
    check_eq("rst_regwrite", 32'(rw[0]), 32'd0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(0, LW, 3'd2, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: BNE_EN, default 1, 1 = BEQ state also executes bne (funct3=001).
REQ-002 Parameter: JAL_EN, default 1, 1 = jal (1101111) supported.
REQ-003 Parameter: IMM_EN, default 1, 1 = I-type ALU (0010011) supported.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- op  in  7  opcode from instruction register.
- funct3  in  3  funct3 from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select (0 = PC, 1 = ALUOut).
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = Imm, 10 = const 4.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- state  out  4  current state code (debug).

Function
REQ-005 Moore FSM, registered state; all outputs except PCWrite and ImmSrc SHALL decode from state only.
REQ-006 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH on the next cycle.
REQ-007 Every output not listed for a state in REQ-008 SHALL be 0 in that state.
REQ-008 State outputs SHALL be:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=mem_ready; PCUpdate=mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR and EXECUTEI: ALUSrcA=10, ALUSrcB=01; ALUOp=00 in MEMADR, 10 in EXECUTEI.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- ALUWB: ResultSrc=00, RegWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-009 PCWrite SHALL be PCUpdate | (Branch & taken).
- taken = zero when funct3=000.
- taken = ~zero when funct3=001 and BNE_EN=1.
- taken = 0 otherwise.
REQ-010 ImmSrc SHALL decode from op combinationally, in every state:
- 0100011 -> 01.
- 1100011 -> 10.
- 1101111 -> 11.
- all other opcodes -> 00.
REQ-011 FETCH SHALL hold while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-012 DECODE transitions SHALL be:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI if IMM_EN=1.
- 1101111 -> JAL if JAL_EN=1.
- 1100011 -> BEQ.
- anything else -> FETCH, with illegal=1 for that DECODE cycle.
REQ-013 MEMADR SHALL go to MEMREAD when op=0000011, otherwise to MEMWRITE.
REQ-014 MEMREAD and MEMWRITE SHALL hold while mem_ready=0; MemWrite SHALL stay asserted throughout the MEMWRITE stall.
REQ-015 On mem_ready=1, MEMREAD SHALL go to MEMWB and MEMWRITE SHALL go to FETCH.
REQ-016 MEMWB, ALUWB and BEQ SHALL go to FETCH; EXECUTER, EXECUTEI and JAL SHALL go to ALUWB.
REQ-017 instr_done SHALL be 1 on the cycle before any return to FETCH from MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ; it SHALL be 0 on illegal-opcode cycles.
REQ-018 Latency with mem_ready held at 1 SHALL be: lw 5 cycles; sw 4; R/I/jal 4; branch 3.

Reset
REQ-019 reset=1 at a clk edge SHALL force state to FETCH from any state, including mid-stall, with priority over all transitions.
REQ-020 With state=FETCH and mem_ready=0 after reset, all outputs SHALL be 0 except ALUSrcB=10 and ResultSrc=10; ImmSrc still follows op.

Verification
REQ-021 lw (op=0000011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; instr_done=1 in state 4.
REQ-022 sw with mem_ready low for 3 cycles in MEMWRITE -> state 5 held 4 cycles; MemWrite=1 for all 4; next state 0.
REQ-023 Branch in state 10:
- funct3=000, zero=1 -> PCWrite=1.
- funct3=001, zero=0, BNE_EN=1 -> PCWrite=1.
- funct3=001, BNE_EN=0 -> PCWrite=0.
REQ-024 op=1101111 -> states 0,1,9,8,0 with PCWrite=1 in 9 and ImmSrc=11; with JAL_EN=0 -> illegal pulse in state 1, then state 0.
REQ-025 reset asserted during a MEMREAD stall -> state=0 at the next edge; RegWrite never asserted.
